rf_pulse_deframer: RTL and testbench
====================================

// Module: rf_pulse_deframer
// PURPOSE
//  Receive front end for the RF link, directly upstream of the APB/SPI RX path.
//  Converts rfin pulses into bits: one bit per sh_en window, 1 = at least one rfin
//  rising edge seen in the window. Bits shift into a 64-bit register; a sync-mask
//  match latches the packet and pulses pkt_rec. The APB side then reads the packet bytes.
// PARAMETERS
//  PKT_W      64                      packet width in bits
//  SYNC_MASK  64'h7C00_001F_0000_0000 bits checked for sync (62:58, 36:32)
//  SYNC_PAT   64'h7C00_001F_0000_0000 required value of the masked bits
//  SYNC_STG   2                       rfin synchronizer depth (>=2)
// PORTS
//  i_PCLK       in   1      system clock; all logic on the rising edge
//  i_PRESETn    in   1      asynchronous active-low reset
//  i_rx_en      in   1      RX mode; 0 = deframer idle and cleared
//  rfin         in   1      asynchronous RF pulse input; min high width 1.5 PCLK
//  sh_en        in   1      bit-window strobe, synchronous to i_PCLK, 1-cycle pulse
//  i_pkt_ack    in   1      1-cycle pulse: consumer has read o_pkt_data
//  o_pkt_data   out  PKT_W  latched packet, bit PKT_W-1 = first bit received
//  pkt_rec      out  1      1-cycle pulse on packet latch
//  o_pkt_valid  out  1      packet held and not yet acknowledged
//  o_overrun    out  1      sticky: a sync match was dropped while o_pkt_valid=1
//  o_bit_cnt    out  7      bits shifted since last clear, saturates at PKT_W
// BEHAVIOUR
//  Reset (async on i_PRESETn low): shift reg, o_pkt_data = 0; pkt_rec, o_pkt_valid,
//   o_overrun, hit flag = 0; o_bit_cnt = 0; synchronizer flops = 0.
//  rfin path: SYNC_STG-flop synchronizer, then rising-edge detect (sync_q & ~sync_q_d).
//   Edge sets the window hit flag. An edge in the same cycle as sh_en counts for
//   the closing window.
//  States: IDLE (i_rx_en=0) / HUNT (bit_cnt<PKT_W) / ARMED (bit_cnt==PKT_W).
//   IDLE: shift reg, hit flag, bit_cnt held at 0. o_pkt_data/o_pkt_valid/o_overrun keep value.
//   Transition IDLE->HUNT when i_rx_en=1. Any state->IDLE when i_rx_en=0, next cycle.
//  On sh_en (HUNT/ARMED): sr <= {sr[PKT_W-2:0], hit|edge}; hit <= 0;
//   bit_cnt <= min(bit_cnt+1, PKT_W).
//  Sync check: combinational on next-shift value sr_n, evaluated on sh_en only when
//   the new bit_cnt==PKT_W, i.e. a full 64 fresh bits.
//   Match = ((sr_n & SYNC_MASK) == SYNC_PAT).
//   Match with o_pkt_valid=0: o_pkt_data <= sr_n; o_pkt_valid <= 1; pkt_rec=1 next cycle.
//   Match with o_pkt_valid=1: data not overwritten, o_overrun <= 1, no pkt_rec.
//   Any match: bit_cnt <= 0 and sr <= 0, so frames never overlap. State -> HUNT.
//   No match in ARMED: sliding window, checked again on every sh_en.
//  pkt_rec latency: exactly 1 cycle after the sh_en cycle that completes the match.
//  i_pkt_ack: clears o_pkt_valid and o_overrun next cycle. Ignored when valid=0.
//   Ack in the same cycle as a new match: the new packet is accepted, valid stays 1,
//   o_overrun cleared.
//  sh_en while hit=0 and no edge: shifts in 0. Two sh_en in a row: second window is empty, gives 0.
//  Multiple rfin edges in one window still give a single 1.
// TESTING
//  T1 reset: assert i_PRESETn=0 mid-frame (bit_cnt=30) -> all outputs 0 immediately, bit_cnt restarts at 0.
//  T2 frame: drive 64 windows, 1 ms period, 100 ns rfin pulse when bit=1, pattern
//     64'h7DD4_EC5F_595B_51FF -> pkt_rec pulse 1 cycle after 64th sh_en,
//     o_pkt_data=64'h7DD4EC5F595B51FF, o_pkt_valid=1.
//  T3 no-sync: 64 windows of 64'h0123_4567_89AB_CDEF (bits 62:58 != 11111)
//     -> no pkt_rec, bit_cnt=64. Then sliding bits forming a match -> pkt_rec on the completing window.
//  T4 overrun: second valid frame without i_pkt_ack -> o_overrun=1, o_pkt_data unchanged.
//     i_pkt_ack -> valid=0, overrun=0.
//  T5 edge cases: rfin edge coincident with sh_en -> counted in closing window;
//     3 pulses in one window -> single 1; i_rx_en=0 for 1 cycle mid-frame -> bit_cnt=0.
//  T6 jitter: +/-5% random period/position jitter over 100 frames -> all 100 packets received bit-exact.

Source files
------------

// File: rtl/rf_pulse_deframer.sv
// RF pulse deframer: turns synchronized rfin rising edges into one bit per sh_en window,
// hunts a 64-bit shift register for the sync pattern and latches matching packets.
module rf_pulse_deframer #(
   parameter int unsigned      PKT_W     = 64,
   parameter logic [PKT_W-1:0] SYNC_MASK = 64'h7C00_001F_0000_0000,
   parameter logic [PKT_W-1:0] SYNC_PAT  = 64'h7C00_001F_0000_0000,
   parameter int unsigned      SYNC_STG  = 2
) (
   input  logic             i_PCLK,
   input  logic             i_PRESETn,
   input  logic             i_rx_en,
   input  logic             rfin,
   input  logic             sh_en,
   input  logic             i_pkt_ack,
   output logic [PKT_W-1:0] o_pkt_data,
   output logic             pkt_rec,
   output logic             o_pkt_valid,
   output logic             o_overrun,
   output logic [6:0]       o_bit_cnt,
   output logic [1:0]       o_state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HUNT  = 2'd1,
      ST_ARMED = 2'd2
   } state_t;

   localparam logic [6:0] FULL = 7'(PKT_W);

   state_t               state_q, state_d;
   logic [SYNC_STG-1:0]  sync_q, sync_d;
   logic                 sync_dly_q, sync_dly_d;
   logic [PKT_W-1:0]     sr_q, sr_d;
   logic                 hit_q, hit_d;
   logic [6:0]           cnt_q, cnt_d;
   logic [PKT_W-1:0]     data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ovr_q, ovr_d;
   logic                 rec_q, rec_d;

   logic                 rf_edge;
   logic [PKT_W-1:0]     sr_n;
   logic [6:0]           cnt_n;
   logic                 match;

   always_comb begin
      sync_d     = {sync_q[SYNC_STG-2:0], rfin};
      sync_dly_d = sync_q[SYNC_STG-1];
      rf_edge    = sync_q[SYNC_STG-1] & ~sync_dly_q;

      // An edge arriving with sh_en belongs to the window being closed.
      sr_n  = {sr_q[PKT_W-2:0], hit_q | rf_edge};
      cnt_n = (cnt_q == FULL) ? FULL : 7'(cnt_q + 7'd1);
      match = (cnt_n == FULL) && ((sr_n & SYNC_MASK) == SYNC_PAT);

      state_d = state_q;
      sr_d    = sr_q;
      hit_d   = hit_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      rec_d   = 1'b0;

      if (i_pkt_ack) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end

      if (!i_rx_en) begin
         state_d = ST_IDLE;
         sr_d    = '0;
         hit_d   = 1'b0;
         cnt_d   = '0;
      end else if (state_q == ST_IDLE) begin
         state_d = ST_HUNT;
         sr_d    = '0;
         hit_d   = 1'b0;
         cnt_d   = '0;
      end else begin
         hit_d = hit_q | rf_edge;
         if (sh_en) begin
            hit_d = 1'b0;
            sr_d  = sr_n;
            cnt_d = cnt_n;
            if (match) begin
               // Restart from an empty register so consecutive frames never overlap.
               sr_d  = '0;
               cnt_d = '0;
               if (!valid_q || i_pkt_ack) begin
                  data_d  = sr_n;
                  valid_d = 1'b1;
                  ovr_d   = 1'b0;
                  rec_d   = 1'b1;
               end else begin
                  ovr_d = 1'b1;
               end
            end
         end
         state_d = (cnt_d == FULL) ? ST_ARMED : ST_HUNT;
      end
   end

   always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
      if (!i_PRESETn) begin
         state_q    <= ST_IDLE;
         sync_q     <= '0;
         sync_dly_q <= 1'b0;
         sr_q       <= '0;
         hit_q      <= 1'b0;
         cnt_q      <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         ovr_q      <= 1'b0;
         rec_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_q     <= sync_d;
         sync_dly_q <= sync_dly_d;
         sr_q       <= sr_d;
         hit_q      <= hit_d;
         cnt_q      <= cnt_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         ovr_q      <= ovr_d;
         rec_q      <= rec_d;
      end
   end

   assign o_pkt_data  = data_q;
   assign pkt_rec     = rec_q;
   assign o_pkt_valid = valid_q;
   assign o_overrun   = ovr_q;
   assign o_bit_cnt   = cnt_q;
   assign o_state     = state_q;

endmodule

// File: tb/tb_rf_pulse_deframer.sv
// Randomized bench for rf_pulse_deframer: pulse-coded windows against a bit-queue
// reference model of the packet/sync/overrun rules.
module tb_rf_pulse_deframer;

   localparam logic [63:0] MASK = 64'h7C00_001F_0000_0000;
   localparam logic [63:0] PAT  = 64'h7C00_001F_0000_0000;

   logic        clk;
   logic        rst_n;
   logic        rx_en;
   logic        rfin;
   logic        sh_en;
   logic        pkt_ack;
   logic [63:0] pkt_data;
   logic        pkt_rec;
   logic        pkt_valid;
   logic        overrun;
   logic [6:0]  bit_cnt;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   bit          win_q[$];
   logic [63:0] exp_q[$];
   logic        exp_valid;
   logic        exp_ovr;
   logic        exp_rec;
   logic [63:0] exp_data;

   rf_pulse_deframer dut (
      .i_PCLK     (clk),
      .i_PRESETn  (rst_n),
      .i_rx_en    (rx_en),
      .rfin       (rfin),
      .sh_en      (sh_en),
      .i_pkt_ack  (pkt_ack),
      .o_pkt_data (pkt_data),
      .pkt_rec    (pkt_rec),
      .o_pkt_valid(pkt_valid),
      .o_overrun  (overrun),
      .o_bit_cnt  (bit_cnt),
      .o_state    (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      win_q.delete();
      exp_valid = 1'b0;
      exp_ovr   = 1'b0;
      exp_rec   = 1'b0;
      exp_data  = '0;
   endtask

   // One received bit: keep the last 64 fresh bits, test the sync rule once 64 are held.
   task automatic model_bit(input bit b, input bit ack);
      logic [63:0] val;
      bit          matched;
      exp_rec = 1'b0;
      matched = 1'b0;
      val     = '0;
      win_q.push_back(b);
      if (win_q.size() > 64) void'(win_q.pop_front());
      if (win_q.size() == 64) begin
         for (int i = 0; i < 64; i++) val[63-i] = win_q[i];
         matched = ((val & MASK) == PAT);
      end
      if (matched) begin
         win_q.delete();
         if (!exp_valid || ack) begin
            exp_data  = val;
            exp_valid = 1'b1;
            exp_ovr   = 1'b0;
            exp_rec   = 1'b1;
            exp_q.push_back(val);
         end else begin
            exp_ovr = 1'b1;
         end
      end else if (ack) begin
         exp_valid = 1'b0;
         exp_ovr   = 1'b0;
      end
   endtask

   task automatic check_outputs();
      chk("pkt_rec", {63'd0, pkt_rec}, {63'd0, exp_rec});
      if (pkt_rec) begin
         if (exp_q.size() > 0) chk("rec_data", pkt_data, exp_q.pop_front());
      end
      chk("pkt_valid", {63'd0, pkt_valid}, {63'd0, exp_valid});
      chk("overrun", {63'd0, overrun}, {63'd0, exp_ovr});
      chk("pkt_data", pkt_data, exp_data);
      chk("bit_cnt", {57'd0, bit_cnt}, 64'(win_q.size()));
   endtask

   // driver: one window of len cycles, np pulses (2 high, 2 low) from cycle pos, sh_en on the last cycle
   task automatic drive_window(input bit b, input int np, input int len, input int pos, input bit ack);
      logic rf;
      for (int c = 0; c < len; c++) begin
         @(negedge clk);
         rf = 1'b0;
         for (int k = 0; k < np; k++)
            if (b && (c == pos + 4*k || c == pos + 4*k + 1)) rf = 1'b1;
         rfin    = rf;
         sh_en   = (c == len - 1);
         pkt_ack = ack && (c == len - 1);
      end
      model_bit(b, ack);
      @(negedge clk);
      rfin    = 1'b0;
      sh_en   = 1'b0;
      pkt_ack = 1'b0;
      check_outputs();
   endtask

   // mode 0: jittered period/position, mode 1: edge coincident with sh_en, mode 2: 3 pulses per window
   task automatic send_bit(input bit b, input int mode, input bit ack);
      int len;
      int pos;
      case (mode)
         1: begin
            len = 8;
            pos = len - 3;
            drive_window(b, 1, len, pos, ack);
         end
         2: begin
            len = 16;
            pos = $urandom_range(0, 5);
            drive_window(b, 3, len, pos, ack);
         end
         default: begin
            len = $urandom_range(7, 9);
            if (!b && $urandom_range(0, 7) == 0) len = 1;
            pos = b ? $urandom_range(0, len - 3) : 0;
            drive_window(b, 1, len, pos, ack);
         end
      endcase
   endtask

   task automatic send_frame(input logic [63:0] v, input int mode, input bit ack_last);
      for (int i = 63; i >= 0; i--) send_bit(v[i], mode, ack_last && (i == 0));
   endtask

   function automatic logic [63:0] rand_sync_frame();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return (r & ~MASK) | PAT;
   endfunction

   task automatic do_ack();
      @(negedge clk);
      pkt_ack   = 1'b1;
      exp_valid = 1'b0;
      exp_ovr   = 1'b0;
      exp_rec   = 1'b0;
      @(negedge clk);
      pkt_ack = 1'b0;
      chk("ack_valid", {63'd0, pkt_valid}, 64'd0);
      chk("ack_overrun", {63'd0, overrun}, 64'd0);
      chk("ack_rec", {63'd0, pkt_rec}, 64'd0);
   endtask

   task automatic rx_off(input int n);
      @(negedge clk);
      rx_en = 1'b0;
      for (int i = 1; i < n; i++) @(negedge clk);
      win_q.delete();
      exp_rec = 1'b0;
      @(negedge clk);
      rx_en = 1'b1;
      chk("rx_off_cnt", {57'd0, bit_cnt}, 64'd0);
      chk("rx_off_valid", {63'd0, pkt_valid}, {63'd0, exp_valid});
      @(negedge clk);
   endtask

   // Two sh_en on consecutive cycles: a pulse-filled window followed by an empty one.
   task automatic double_shen();
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         rfin  = (c == 0 || c == 1);
         sh_en = (c == 6 || c == 7);
      end
      model_bit(1'b1, 1'b0);
      model_bit(1'b0, 1'b0);
      @(negedge clk);
      rfin  = 1'b0;
      sh_en = 1'b0;
      check_outputs();
   endtask

   initial begin
      rst_n   = 1'b0;
      rx_en   = 1'b0;
      rfin    = 1'b0;
      sh_en   = 1'b0;
      pkt_ack = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_data", pkt_data, 64'd0);
      chk("rst_valid", {63'd0, pkt_valid}, 64'd0);
      chk("rst_rec", {63'd0, pkt_rec}, 64'd0);
      chk("rst_overrun", {63'd0, overrun}, 64'd0);
      chk("rst_cnt", {57'd0, bit_cnt}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      rx_en = 1'b1;
      @(negedge clk);

      // T2: reference frame
      send_frame(64'h7DD4_EC5F_595B_51FF, 0, 1'b0);
      chk("t2_data", pkt_data, 64'h7DD4_EC5F_595B_51FF);
      chk("t2_valid", {63'd0, pkt_valid}, 64'd1);

      // T1: asynchronous reset 30 bits into a frame
      for (int i = 0; i < 30; i++) send_bit(1'($urandom), 0, 1'b0);
      chk("t1_cnt_before", {57'd0, bit_cnt}, 64'd30);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("t1_data", pkt_data, 64'd0);
      chk("t1_valid", {63'd0, pkt_valid}, 64'd0);
      chk("t1_rec", {63'd0, pkt_rec}, 64'd0);
      chk("t1_overrun", {63'd0, overrun}, 64'd0);
      chk("t1_cnt", {57'd0, bit_cnt}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_bit(1'b1, 0, 1'b0);
      chk("t1_restart_cnt", {57'd0, bit_cnt}, 64'd1);
      rx_off(2);

      // T3: no sync, then a sliding match
      send_frame(64'h0123_4567_89AB_CDEF, 0, 1'b0);
      chk("t3_cnt_full", {57'd0, bit_cnt}, 64'd64);
      chk("t3_no_valid", {63'd0, pkt_valid}, 64'd0);
      send_frame(64'h7DD4_EC5F_595B_51FF, 0, 1'b0);

      // T4: overrun, ack, ack coincident with a new match
      exp_data = pkt_data === exp_data ? exp_data : exp_data;
      send_frame(rand_sync_frame(), 0, 1'b0);
      chk("t4_overrun", {63'd0, overrun}, 64'd1);
      do_ack();
      send_frame(rand_sync_frame(), 0, 1'b0);
      send_frame(rand_sync_frame(), 0, 1'b0);
      chk("t4_overrun2", {63'd0, overrun}, 64'd1);
      send_frame(rand_sync_frame(), 0, 1'b1);
      chk("t4_ack_match_ovr", {63'd0, overrun}, 64'd0);
      chk("t4_ack_match_valid", {63'd0, pkt_valid}, 64'd1);
      do_ack();

      // T5: coincident edges, multi-pulse windows, back-to-back sh_en, rx_en drop
      send_frame(rand_sync_frame(), 1, 1'b0);
      do_ack();
      send_frame(rand_sync_frame(), 2, 1'b0);
      do_ack();
      for (int i = 0; i < 10; i++) send_bit(1'($urandom), 0, 1'b0);
      double_shen();
      for (int i = 0; i < 8; i++) send_bit(1'($urandom), 0, 1'b0);
      rx_off(1);

      // T6: jittered frames, each acknowledged
      for (int f = 0; f < 100; f++) begin
         send_frame(rand_sync_frame(), 0, 1'b0);
         do_ack();
      end

      chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
